// File: rtl/vec_store_pkg.sv
// Shared vector-store definitions: FSM state type and EEW width encodings.
// The load unit and the vector controller reuse these too.
package vec_store_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStore = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [2:0] EEW8  = 3'b000;
  localparam logic [2:0] EEW16 = 3'b101;
  localparam logic [2:0] EEW32 = 3'b110;

  // Element size in bytes; 0 marks an illegal encoding.
  function automatic logic [2:0] eew_bytes(input logic [2:0] width);
    logic [2:0] bytes;
    case (width)
      EEW8:    bytes = 3'd1;
      EEW16:   bytes = 3'd2;
      EEW32:   bytes = 3'd4;
      default: bytes = 3'd0;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/vec_store_lane_align.sv
// Lane alignment for the vector store unit (combinational).
// Extracts element i_idx of width i_width from i_data, replicates it across the
// memory bus and builds the byte strobes starting at the address lane i_addr_lo.
//   i_data      captured vector register group
//   i_idx       element index
//   i_width     EEW encoding
//   i_addr_lo   low address bits (byte lane within the bus word)
//   o_data      replicated element
//   o_byte_en   EEW/8 consecutive strobes shifted to the address lane
module vec_store_lane_align
  import vec_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned LANE_W     = 2
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [2:0]            i_width,
  input  logic [LANE_W-1:0]     i_addr_lo,
  output logic [XLEN-1:0]       o_data,
  output logic [XLEN/8-1:0]     o_byte_en
);

  localparam int unsigned SH_W = IDX_W + 5;
  localparam int unsigned BE_W = XLEN / 8;

  logic [SH_W-1:0] w_bit_off;
  logic [BE_W-1:0] w_be_base;
  logic [XLEN-1:0] w_elem;

  always_comb begin
    w_bit_off = '0;
    w_be_base = '0;
    case (i_width)
      EEW8: begin
        w_bit_off = SH_W'(i_idx) << 3;
        w_be_base = BE_W'(4'b0001);
      end
      EEW16: begin
        w_bit_off = SH_W'(i_idx) << 4;
        w_be_base = BE_W'(4'b0011);
      end
      EEW32: begin
        w_bit_off = SH_W'(i_idx) << 5;
        w_be_base = BE_W'(4'b1111);
      end
      default: ;
    endcase
  end

  // Only the low XLEN bits of the shifted group can hold the element.
  assign w_elem = XLEN'(i_data >> w_bit_off);

  always_comb begin
    o_data = '0;
    case (i_width)
      EEW8:    o_data = {(XLEN/8){w_elem[7:0]}};
      EEW16:   o_data = {(XLEN/16){w_elem[15:0]}};
      EEW32:   o_data = {(XLEN/32){w_elem[31:0]}};
      default: ;
    endcase
  end

  assign o_byte_en = w_be_base << i_addr_lo;

endmodule

// File: rtl/vec_store_unit.sv
// Vector store unit: captures a vector register group on i_start and writes each
// active element to memory over a valid/ready handshake, skipping v0-masked ones.
//   i_start/base_addr/stride/stride_sel/width/vl/vm/vs3_data/v0_mask_data: request
//   i_mem_ready       memory accepts the current write
//   o_lsu2mem_*       registered write request (addr, replicated data, strobes, valid)
//   o_busy            high outside IDLE
//   o_is_stored       completion pulse; o_store_err error pulse alongside it
module vec_store_unit
  import vec_store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MASK_WIDTH = 512
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [XLEN-1:0]       i_base_addr,
  input  logic [XLEN-1:0]       i_stride,
  input  logic                  i_stride_sel,
  input  logic [2:0]            i_width,
  input  logic [XLEN-1:0]       i_vl,
  input  logic                  i_vm,
  input  logic [DATA_WIDTH-1:0] i_vs3_data,
  input  logic [MASK_WIDTH-1:0] i_v0_mask_data,
  input  logic                  i_mem_ready,
  output logic [XLEN-1:0]       o_lsu2mem_addr,
  output logic [XLEN-1:0]       o_lsu2mem_data,
  output logic [XLEN/8-1:0]     o_lsu2mem_byte_en,
  output logic                  o_lsu2mem_wr_en,
  output logic                  o_busy,
  output logic                  o_is_stored,
  output logic                  o_store_err
);

  localparam int unsigned IDX_W  = $clog2(DATA_WIDTH / 8);
  localparam int unsigned VL_W   = IDX_W + 1;
  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);

  state_e                r_state, w_state_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [XLEN-1:0]       r_addr, w_addr_d;
  logic                  r_err, w_err_d;
  logic [XLEN-1:0]       r_stride;
  logic                  r_stride_sel;
  logic [2:0]            r_width;
  logic [VL_W-1:0]       r_vl;
  logic                  r_vm;
  logic [DATA_WIDTH-1:0] r_vs3;
  logic [MASK_WIDTH-1:0] r_v0;

  logic                  r_wr_en;
  logic [XLEN-1:0]       r_mem_addr, r_mem_data;
  logic [BE_W-1:0]       r_byte_en;

  logic                  w_load;
  logic                  w_idle;
  logic [2:0]            w_width_src;
  logic                  w_vm_src;
  logic [DATA_WIDTH-1:0] w_vs3_src;
  logic [MASK_WIDTH-1:0] w_v0_src;
  logic [2:0]            w_eew_bytes;
  logic [LANE_W-1:0]     w_align_mask;
  logic [XLEN-1:0]       w_max_vl;
  logic                  w_req_ok;
  logic                  w_cur_active, w_cur_misal, w_last;
  logic [XLEN-1:0]       w_step;
  logic                  w_nxt_active, w_nxt_misal, w_wr_en_d;
  logic [XLEN-1:0]       w_lane_data;
  logic [BE_W-1:0]       w_lane_be;

  // Outputs are registered from next-state values, so in IDLE the request
  // inputs stand in for the not-yet-captured registers.
  assign w_idle      = (r_state == StIdle);
  assign w_width_src = w_idle ? i_width        : r_width;
  assign w_vm_src    = w_idle ? i_vm           : r_vm;
  assign w_vs3_src   = w_idle ? i_vs3_data     : r_vs3;
  assign w_v0_src    = w_idle ? i_v0_mask_data : r_v0;

  assign w_eew_bytes  = eew_bytes(w_width_src);
  assign w_align_mask = LANE_W'(w_eew_bytes - 3'd1);

  always_comb begin
    w_max_vl = '0;
    case (i_width)
      EEW8:    w_max_vl = XLEN'(DATA_WIDTH / 8);
      EEW16:   w_max_vl = XLEN'(DATA_WIDTH / 16);
      EEW32:   w_max_vl = XLEN'(DATA_WIDTH / 32);
      default: ;
    endcase
  end

  assign w_req_ok = (w_eew_bytes != 3'd0) && (i_vl <= w_max_vl) &&
                    ((i_base_addr[LANE_W-1:0] & w_align_mask) == '0);

  assign w_cur_active = r_vm | r_v0[r_idx];
  assign w_cur_misal  = |(r_addr[LANE_W-1:0] & w_align_mask);
  assign w_last       = ({1'b0, r_idx} == (r_vl - VL_W'(1)));
  assign w_step       = r_stride_sel ? r_stride : XLEN'(w_eew_bytes);

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_addr_d  = r_addr;
    w_err_d   = r_err;
    w_load    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (!w_req_ok) begin
            w_state_d = StDone;
            w_err_d   = 1'b1;
          end else if (i_vl == '0) begin
            w_state_d = StDone;
            w_err_d   = 1'b0;
          end else begin
            w_state_d = StStore;
            w_load    = 1'b1;
            w_idx_d   = '0;
            w_addr_d  = i_base_addr;
            w_err_d   = 1'b0;
          end
        end
      end
      StStore: begin
        if (w_cur_active && w_cur_misal) begin
          // Strided walk hit a misaligned address: abort without writing it.
          w_state_d = StDone;
          w_err_d   = 1'b1;
        end else if (!w_cur_active || i_mem_ready) begin
          if (w_last) begin
            w_state_d = StDone;
          end else begin
            w_idx_d  = r_idx + IDX_W'(1);
            w_addr_d = r_addr + w_step;
          end
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_nxt_active = w_vm_src | w_v0_src[w_idx_d];
  assign w_nxt_misal  = |(w_addr_d[LANE_W-1:0] & w_align_mask);
  assign w_wr_en_d    = (w_state_d == StStore) && w_nxt_active && !w_nxt_misal;

  vec_store_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .XLEN       (XLEN),
    .IDX_W      (IDX_W),
    .LANE_W     (LANE_W)
  ) u_lane_align (
    .i_data    (w_vs3_src),
    .i_idx     (w_idx_d),
    .i_width   (w_width_src),
    .i_addr_lo (w_addr_d[LANE_W-1:0]),
    .o_data    (w_lane_data),
    .o_byte_en (w_lane_be)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_addr       <= '0;
      r_err        <= 1'b0;
      r_stride     <= '0;
      r_stride_sel <= 1'b0;
      r_width      <= '0;
      r_vl         <= '0;
      r_vm         <= 1'b0;
      r_vs3        <= '0;
      r_v0         <= '0;
      r_wr_en      <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_byte_en    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_addr     <= w_addr_d;
      r_err      <= w_err_d;
      r_wr_en    <= w_wr_en_d;
      r_mem_addr <= w_wr_en_d ? w_addr_d    : '0;
      r_mem_data <= w_wr_en_d ? w_lane_data : '0;
      r_byte_en  <= w_wr_en_d ? w_lane_be   : '0;
      if (w_load) begin
        r_stride     <= i_stride;
        r_stride_sel <= i_stride_sel;
        r_width      <= i_width;
        r_vl         <= i_vl[VL_W-1:0];
        r_vm         <= i_vm;
        r_vs3        <= i_vs3_data;
        r_v0         <= i_v0_mask_data;
      end
    end
  end

  assign o_lsu2mem_addr    = r_mem_addr;
  assign o_lsu2mem_data    = r_mem_data;
  assign o_lsu2mem_byte_en = r_byte_en;
  assign o_lsu2mem_wr_en   = r_wr_en;
  assign o_busy            = (r_state != StIdle);
  assign o_is_stored       = (r_state == StDone);
  assign o_store_err       = (r_state == StDone) && r_err;

endmodule

// File: doc/vec_store_unit.md
# vec_store_unit

Vector store unit: the write-to-memory counterpart of the vector load path. On `start` it captures one vector register group from the vector register file (vs3 data) plus base address, stride and element width. It then issues one memory write per active element over a valid/ready handshake to main memory, skipping elements that v0 masks off. It sits beside the load unit in the vector processor datapath; the vector controller drives it, and it reports completion back to the controller.

## Interface
Parameters:
- `DATA_WIDTH`, 512: width of the captured vector register group (max LMUL × VLEN).
- `XLEN`, 32: address and scalar width; also the memory data bus width.
- `MASK_WIDTH`, 512: width of the v0 mask input; bit i masks element i.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request from the controller; sampled only in IDLE.
- `base_addr` in XLEN: rs1 base byte address.
- `stride` in XLEN: rs2 byte stride, two's complement; used only when `stride_sel`=1.
- `stride_sel` in 1: 0 = unit stride, 1 = constant stride.
- `width` in 3: EEW encoding. 000 = 8-bit, 101 = 16-bit, 110 = 32-bit. Any other value is illegal.
- `vl` in XLEN: number of elements to store.
- `vm` in 1: 1 = unmasked, 0 = masked by `v0_mask_data`.
- `vs3_data` in DATA_WIDTH: source data; element i occupies bits [i·EEW +: EEW].
- `v0_mask_data` in MASK_WIDTH: mask register contents.
- `mem_ready` in 1: memory accepts the current write this cycle.
- `lsu2mem_addr` out XLEN: write byte address.
- `lsu2mem_data` out XLEN: write data, lane-aligned.
- `lsu2mem_byte_en` out XLEN/8: byte strobes.
- `lsu2mem_wr_en` out 1: write valid.
- `busy` out 1: high in every state except IDLE.
- `is_stored` out 1: one-cycle completion pulse.
- `store_err` out 1: one-cycle error pulse, coincident with `is_stored`.

## Operation
- FSM states: IDLE, STORE, DONE.
- IDLE -> STORE on `start`, when the request is legal and `vl`≠0. On this transition the unit registers `base_addr`, `stride`, `stride_sel`, `width`, `vl`, `vm`, `vs3_data` and `v0_mask_data`, and clears the element counter `idx` and the running address.
- IDLE -> DONE on `start` with `vl`=0. No writes are issued.
- IDLE -> DONE with the error flag set on `start` when any of these hold: `width` is illegal; `vl` > DATA_WIDTH/EEW; the base address is misaligned to EEW. No writes are issued.
- STORE, element `idx` active (`vm`=1 or `v0[idx]`=1): assert `lsu2mem_wr_en`. The write completes in the cycle `mem_ready` is high. Then `idx` increments and the address advances.
- STORE, element `idx` inactive: no write. `idx` advances in the same cycle without waiting for `mem_ready`.
- Address step: EEW/8 bytes for unit stride; `stride` for strided, added modulo 2^XLEN.
- STORE -> DONE when the last element (`idx` = `vl`−1) completes or is skipped.
- Strided misalignment: if a computed element address is misaligned to EEW, the unit issues no write for that element, goes to DONE and flags an error. Writes already completed stay done.
- Lane placement: the element is replicated across the bus. `lsu2mem_byte_en` has EEW/8 consecutive bits set, starting at `addr[1:0]`.
- DONE: pulse `is_stored`, and pulse `store_err` if the error flag is set; return to IDLE next cycle.
- `start` in STORE or DONE is ignored.
- Masked stores leave memory untouched for masked-off elements; there is no tail or agnostic write-back.

## Timing
- Reset (asynchronous): state IDLE. All outputs are 0, including `lsu2mem_addr`, `lsu2mem_data` and `lsu2mem_byte_en`. `idx` is cleared. An in-flight write is abandoned immediately.
- The first write request appears the cycle after `start` is accepted, and is registered.
- While `lsu2mem_wr_en`=1 and `mem_ready`=0, the address, data and strobes stay stable.
- Throughput is one element per cycle when `mem_ready` is held high. With N elements, all active, `is_stored` pulses in cycle N+1 after the `start` cycle.
- `busy` rises the cycle after `start` and falls the cycle after `is_stored`.
- `wr_en` is registered: the next element's request is presented the cycle after a handshake, with no bubble.

## Structure
- Shared package `vec_store_pkg`: a state enum (IDLE/STORE/DONE) and width-encoding constants (EEW8=3'b000, EEW16=3'b101, EEW32=3'b110). These are reused by the controller and the load unit.
- One sub-module, `vec_store_lane_align`: combinational extraction of element `idx` from the captured data, replication, and byte-strobe generation from EEW and `addr[1:0]`.

## Test plan
- Unit stride, EEW32, `vl`=4, base 0x100, `mem_ready`=1: writes go to 0x100, 0x104, 0x108, 0x10C with strobes 4'b1111. `is_stored` pulses in cycle 5 after `start`.
- Unit stride, EEW8, `vl`=5, base 0x203: byte strobes go 4'b1000, 0001, 0010, 0100, 1000 at addresses 0x203 to 0x207, with the data byte replicated across the bus.
- Strided, EEW16, `stride`=−8, base 0x40, `vl`=3: writes go to 0x40, 0x38, 0x30. Stalling `mem_ready` low for 3 cycles on the second write holds the address, data and strobes stable.
- Masked, `vm`=0, v0=4'b0101, `vl`=4, EEW32: only elements 0 and 2 are written. `is_stored` arrives with no stall for the skipped elements.
- Error cases, each giving a DONE pulse with `store_err`=1 and zero writes:
  - `width`=3'b111;
  - `vl`=0 (`store_err`=0 in this case only);
  - EEW32 with base 0x102.
- Reset asserted mid-STORE during a stalled write: `lsu2mem_wr_en` and `busy` drop in the same cycle. After release, a new `start` runs normally.
